// File: rtl/cache_pkg.sv
// Shared address-field widths, geometry and FSM state encoding for the
// direct-mapped write-through cache controller.
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int DATA_W   = 32;

    localparam int LINES = 32;
    localparam int WORDS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_MEM  = 2'd2
    } state_t;

endpackage

// File: rtl/cache_array.sv
// Tag, valid and data storage for the cache: one combinational read port,
// a single-word write port and a whole-line fill port.
module cache_array #(
    parameter int LINES = cache_pkg::LINES,
    parameter int WORDS = cache_pkg::WORDS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [cache_pkg::INDEX_W-1:0]             rd_index,
    input  logic [cache_pkg::OFFSET_W-1:0]            rd_offset,
    output logic                                      rd_valid,
    output logic [cache_pkg::TAG_W-1:0]               rd_tag,
    output logic [cache_pkg::DATA_W-1:0]              rd_word,
    input  logic                                      wr_en,
    input  logic [cache_pkg::INDEX_W-1:0]             wr_index,
    input  logic [cache_pkg::OFFSET_W-1:0]            wr_offset,
    input  logic [cache_pkg::DATA_W-1:0]              wr_data,
    input  logic                                      fill_en,
    input  logic [cache_pkg::INDEX_W-1:0]             fill_index,
    input  logic [cache_pkg::TAG_W-1:0]               fill_tag,
    input  logic [WORDS*cache_pkg::DATA_W-1:0]        fill_data
);
    import cache_pkg::*;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[rd_index][rd_offset];

    // NOTE: non-blocking (<=) for every register so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag and data are left unreset; the cleared valid bits already mask their contents.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_index] <= fill_tag;
            for (int w = 0; w < WORDS; w++) begin
                data_q[fill_index][w] <= fill_data[w*DATA_W +: DATA_W];
            end
        end else if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate blocking cache controller
// with a single outstanding main-memory transaction.
module cache_ctrl #(
    parameter int LINES = cache_pkg::LINES,
    parameter int WORDS = cache_pkg::WORDS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Mem_Read,
    input  logic                                Mem_Write,
    input  logic [cache_pkg::ADDR_W-1:0]        addr,
    input  logic [cache_pkg::DATA_W-1:0]        wdata,
    output logic [cache_pkg::DATA_W-1:0]        rdata,
    output logic                                stall,
    output logic                                mm_read,
    output logic                                mm_write,
    output logic [cache_pkg::ADDR_W-1:0]        mm_addr,
    output logic [cache_pkg::DATA_W-1:0]        mm_wdata,
    input  logic [WORDS*cache_pkg::DATA_W-1:0]  mm_rdata,
    input  logic                                mm_ready
);
    import cache_pkg::*;

    state_t              state_q;
    logic [ADDR_W-1:0]   mm_addr_q;
    logic [DATA_W-1:0]   mm_wdata_q;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [DATA_W-1:0]   line_word;
    logic                hit;
    logic                in_idle;
    logic                wr_en;
    logic                fill_en;

    assign req_tag    = addr[ADDR_W-1 -: TAG_W];
    assign req_index  = addr[OFFSET_W +: INDEX_W];
    assign req_offset = addr[OFFSET_W-1:0];

    assign hit     = line_valid && (line_tag == req_tag);
    assign in_idle = (state_q == IDLE);

    // Fills use the latched block address; reset on the completion edge discards the fill.
    assign wr_en   = in_idle && Mem_Write && hit && !rst;
    assign fill_en = (state_q == RD_MISS) && mm_ready && !rst;

    cache_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (req_index),
        .rd_offset  (req_offset),
        .rd_valid   (line_valid),
        .rd_tag     (line_tag),
        .rd_word    (line_word),
        .wr_en      (wr_en),
        .wr_index   (req_index),
        .wr_offset  (req_offset),
        .wr_data    (wdata),
        .fill_en    (fill_en),
        .fill_index (mm_addr_q[OFFSET_W +: INDEX_W]),
        .fill_tag   (mm_addr_q[ADDR_W-1 -: TAG_W]),
        .fill_data  (mm_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mm_addr_q  <= '0;
            mm_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Mem_Write) begin
                        mm_addr_q  <= addr;
                        mm_wdata_q <= wdata;
                        state_q    <= WR_MEM;
                    end else if (Mem_Read && !hit) begin
                        mm_addr_q <= {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        state_q   <= RD_MISS;
                    end
                end
                RD_MISS: if (mm_ready) state_q <= IDLE;
                WR_MEM:  if (mm_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        stall = 1'b0;
        rdata = '0;
        case (state_q)
            IDLE: begin
                stall = Mem_Write || (Mem_Read && !hit);
                if (Mem_Read && !Mem_Write && hit) rdata = line_word;
            end
            RD_MISS: stall = 1'b1;
            WR_MEM:  stall = !mm_ready;
            default: stall = 1'b0;
        endcase
    end

    assign mm_read  = (state_q == RD_MISS);
    assign mm_write = (state_q == WR_MEM);
    assign mm_addr  = mm_addr_q;
    assign mm_wdata = mm_wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl; the bench plays the CPU and
// a main memory whose ready pulse arrives a chosen number of cycles late.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Mem_Read = 1'b0;
    logic         Mem_Write = 1'b0;
    logic [9:0]   addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         stall;
    logic         mm_read;
    logic         mm_write;
    logic [9:0]   mm_addr;
    logic [31:0]  mm_wdata;
    logic [127:0] mm_rdata = '0;
    logic         mm_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // Results of the most recent access() call.
    int          a_stalls;
    int          a_nrd;
    int          a_nwr;
    logic [31:0] a_rd;
    logic [31:0] a_mwd;
    logic [9:0]  a_maddr;
    logic        a_to;

    localparam logic [127:0] BLK_A = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] BLK_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam logic [127:0] BLK_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    localparam logic [127:0] BLK_E = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
    localparam logic [127:0] BLK_F = {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0};
    localparam logic [127:0] BLK_G = {32'h63636363, 32'h62626262, 32'h61616161, 32'h60606060};

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .Mem_Read  (Mem_Read),
        .Mem_Write (Mem_Write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mm_read   (mm_read),
        .mm_write  (mm_write),
        .mm_addr   (mm_addr),
        .mm_wdata  (mm_wdata),
        .mm_rdata  (mm_rdata),
        .mm_ready  (mm_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CPU access held until stall drops; memory answers lat cycles after its first request cycle.
    task automatic access(input logic wr, input logic both, input logic [9:0] a,
                          input logic [31:0] wd, input logic [127:0] blk, input int lat);
        int  busy;
        logic done;
        Mem_Read  = !wr || both;
        Mem_Write = wr;
        addr      = a;
        wdata     = wd;
        mm_rdata  = blk;
        busy = 0; done = 1'b0;
        a_stalls = 0; a_nrd = 0; a_nwr = 0; a_rd = '0; a_mwd = '0; a_maddr = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (mm_read || mm_write) begin
                busy++;
                a_maddr = mm_addr;
                a_mwd   = mm_wdata;
                if (mm_read)  a_nrd++;
                if (mm_write) a_nwr++;
                if (busy == lat + 1) mm_ready = 1'b1;
            end
            #1;
            if (!stall) begin
                a_rd = rdata;
                done = 1'b1;
            end else begin
                a_stalls++;
            end
            step();
            mm_ready = 1'b0;
        end
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        a_to = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (mm_read !== 1'b0) begin failures++; $display("FAIL reset_mm_read: got %b expected 0", mm_read); end
        checks++; if (mm_write !== 1'b0) begin failures++; $display("FAIL reset_mm_write: got %b expected 0", mm_write); end
        checks++; if (mm_addr !== 10'h000) begin failures++; $display("FAIL reset_mm_addr: got %h expected 000", mm_addr); end
        checks++; if (mm_wdata !== 32'h0) begin failures++; $display("FAIL reset_mm_wdata: got %h expected 0", mm_wdata); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        step();
    endtask

    task automatic test_read_miss();
        access(1'b0, 1'b0, 10'h004, 32'h0, BLK_A, 3);
        checks++; if (a_to !== 1'b0) begin failures++; $display("FAIL miss_timeout: got %b expected 0", a_to); end
        checks++; if (a_stalls !== 5) begin failures++; $display("FAIL miss_stall_cycles: got %0d expected 5", a_stalls); end
        checks++; if (a_nrd !== 4) begin failures++; $display("FAIL miss_mm_read_cycles: got %0d expected 4", a_nrd); end
        checks++; if (a_nwr !== 0) begin failures++; $display("FAIL miss_mm_write_cycles: got %0d expected 0", a_nwr); end
        checks++; if (a_maddr !== 10'h004) begin failures++; $display("FAIL miss_mm_addr: got %h expected 004", a_maddr); end
        checks++; if (a_rd !== 32'hA0A0A0A0) begin failures++; $display("FAIL miss_rdata: got %h expected a0a0a0a0", a_rd); end
    endtask

    task automatic test_read_hit();
        access(1'b0, 1'b0, 10'h006, 32'h0, '0, 0);
        checks++; if (a_stalls !== 0) begin failures++; $display("FAIL hit_stall_cycles: got %0d expected 0", a_stalls); end
        checks++; if (a_nrd !== 0) begin failures++; $display("FAIL hit_mm_read_cycles: got %0d expected 0", a_nrd); end
        checks++; if (a_rd !== 32'hA2A2A2A2) begin failures++; $display("FAIL hit_rdata: got %h expected a2a2a2a2", a_rd); end
        addr = 10'h006;
        #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL idle_no_req_rdata: got %h expected 0", rdata); end
    endtask

    task automatic test_write_hit();
        access(1'b1, 1'b0, 10'h005, 32'hDEADBEEF, '0, 2);
        checks++; if (a_stalls !== 3) begin failures++; $display("FAIL wr_hit_stall_cycles: got %0d expected 3", a_stalls); end
        checks++; if (a_nwr !== 3) begin failures++; $display("FAIL wr_hit_mm_write_cycles: got %0d expected 3", a_nwr); end
        checks++; if (a_maddr !== 10'h005) begin failures++; $display("FAIL wr_hit_mm_addr: got %h expected 005", a_maddr); end
        checks++; if (a_mwd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hit_mm_wdata: got %h expected deadbeef", a_mwd); end
        access(1'b0, 1'b0, 10'h005, 32'h0, '0, 0);
        checks++; if (a_nrd !== 0) begin failures++; $display("FAIL wr_hit_reload_mm_read: got %0d expected 0", a_nrd); end
        checks++; if (a_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hit_reload_rdata: got %h expected deadbeef", a_rd); end
        access(1'b0, 1'b0, 10'h004, 32'h0, '0, 0);
        checks++; if (a_rd !== 32'hA0A0A0A0) begin failures++; $display("FAIL wr_hit_neighbour_rdata: got %h expected a0a0a0a0", a_rd); end
    endtask

    task automatic test_write_miss();
        access(1'b1, 1'b0, 10'h3F0, 32'h12345678, '0, 1);
        checks++; if (a_stalls !== 2) begin failures++; $display("FAIL wr_miss_stall_cycles: got %0d expected 2", a_stalls); end
        checks++; if (a_maddr !== 10'h3F0) begin failures++; $display("FAIL wr_miss_mm_addr: got %h expected 3f0", a_maddr); end
        checks++; if (a_mwd !== 32'h12345678) begin failures++; $display("FAIL wr_miss_mm_wdata: got %h expected 12345678", a_mwd); end
        access(1'b0, 1'b0, 10'h3F0, 32'h0, BLK_C, 1);
        checks++; if (a_stalls !== 3) begin failures++; $display("FAIL wr_miss_reload_stall: got %0d expected 3", a_stalls); end
        checks++; if (a_nrd !== 2) begin failures++; $display("FAIL wr_miss_reload_mm_read: got %0d expected 2", a_nrd); end
        checks++; if (a_rd !== 32'hC0C0C0C0) begin failures++; $display("FAIL wr_miss_reload_rdata: got %h expected c0c0c0c0", a_rd); end
    endtask

    task automatic test_read_and_write();
        access(1'b1, 1'b1, 10'h004, 32'h0BADF00D, '0, 0);
        checks++; if (a_stalls !== 1) begin failures++; $display("FAIL both_stall_cycles: got %0d expected 1", a_stalls); end
        checks++; if (a_nrd !== 0) begin failures++; $display("FAIL both_mm_read: got %0d expected 0", a_nrd); end
        checks++; if (a_nwr !== 1) begin failures++; $display("FAIL both_mm_write: got %0d expected 1", a_nwr); end
        checks++; if (a_rd !== 32'h0) begin failures++; $display("FAIL both_rdata: got %h expected 0", a_rd); end
        access(1'b0, 1'b0, 10'h004, 32'h0, '0, 0);
        checks++; if (a_rd !== 32'h0BADF00D) begin failures++; $display("FAIL both_reload_rdata: got %h expected 0badf00d", a_rd); end
    endtask

    task automatic test_ready_in_idle();
        mm_ready = 1'b1;
        step();
        mm_ready = 1'b0;
        #1;
        checks++; if (mm_read !== 1'b0 || mm_write !== 1'b0) begin failures++; $display("FAIL idle_ready_mm_req: got %b%b expected 00", mm_read, mm_write); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_ready_stall: got %b expected 0", stall); end
        step();
        access(1'b0, 1'b0, 10'h004, 32'h0, BLK_F, 0);
        checks++; if (a_stalls !== 0) begin failures++; $display("FAIL idle_ready_hit_stall: got %0d expected 0", a_stalls); end
        checks++; if (a_rd !== 32'h0BADF00D) begin failures++; $display("FAIL idle_ready_hit_rdata: got %h expected 0badf00d", a_rd); end
    endtask

    task automatic test_conflict();
        access(1'b0, 1'b0, 10'h084, 32'h0, BLK_D, 1);
        checks++; if (a_stalls !== 3) begin failures++; $display("FAIL conflict_miss_stall: got %0d expected 3", a_stalls); end
        checks++; if (a_maddr !== 10'h084) begin failures++; $display("FAIL conflict_mm_addr: got %h expected 084", a_maddr); end
        checks++; if (a_rd !== 32'hD0D0D0D0) begin failures++; $display("FAIL conflict_rdata: got %h expected d0d0d0d0", a_rd); end
        access(1'b0, 1'b0, 10'h004, 32'h0, BLK_E, 2);
        checks++; if (a_stalls !== 4) begin failures++; $display("FAIL conflict_back_stall: got %0d expected 4", a_stalls); end
        checks++; if (a_nrd !== 3) begin failures++; $display("FAIL conflict_back_mm_read: got %0d expected 3", a_nrd); end
        checks++; if (a_rd !== 32'hE0E0E0E0) begin failures++; $display("FAIL conflict_back_rdata: got %h expected e0e0e0e0", a_rd); end
        access(1'b0, 1'b0, 10'h007, 32'h0, '0, 0);
        checks++; if (a_stalls !== 0) begin failures++; $display("FAIL conflict_refill_hit_stall: got %0d expected 0", a_stalls); end
        checks++; if (a_rd !== 32'hE3E3E3E3) begin failures++; $display("FAIL conflict_refill_hit_rdata: got %h expected e3e3e3e3", a_rd); end
    endtask

    task automatic test_reset_mid_transaction();
        Mem_Read = 1'b1;
        addr     = 10'h108;
        step();
        #1;
        checks++; if (mm_read !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL rst_rd_pre: got mm_read=%b stall=%b expected 1 1", mm_read, stall); end
        rst = 1'b1;
        Mem_Read = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++; if (mm_read !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_rd_abandon: got mm_read=%b stall=%b expected 0 0", mm_read, stall); end
        mm_rdata = BLK_F;
        mm_ready = 1'b1;
        step();
        mm_ready = 1'b0;
        #1;
        checks++; if (mm_read !== 1'b0 || mm_write !== 1'b0) begin failures++; $display("FAIL rst_rd_late_ready: got %b%b expected 00", mm_read, mm_write); end
        step();
        access(1'b0, 1'b0, 10'h108, 32'h0, BLK_G, 0);
        checks++; if (a_stalls !== 2) begin failures++; $display("FAIL rst_rd_reload_stall: got %0d expected 2", a_stalls); end
        checks++; if (a_rd !== 32'h60606060) begin failures++; $display("FAIL rst_rd_reload_rdata: got %h expected 60606060", a_rd); end

        Mem_Write = 1'b1;
        addr      = 10'h00C;
        wdata     = 32'h55AA55AA;
        step();
        #1;
        checks++; if (mm_write !== 1'b1) begin failures++; $display("FAIL rst_wr_pre: got %b expected 1", mm_write); end
        rst = 1'b1;
        Mem_Write = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++; if (mm_write !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_wr_abandon: got mm_write=%b stall=%b expected 0 0", mm_write, stall); end
        checks++; if (mm_wdata !== 32'h0) begin failures++; $display("FAIL rst_wr_mm_wdata: got %h expected 0", mm_wdata); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_read_and_write();
        test_ready_in_idle();
        test_conflict();
        test_reset_mid_transaction();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
